convolution_processor_ctrl: RTL



---
 rtl/convolution_processor_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/convolution_processor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : convolution_processor_ctrl (+ convolution_processor_adder)
//  Brief    : Sequencer computing Z[i] = sum_j X[j]*Y[i-j] (full linear
//             convolution) over external 1-cycle-latency RAMs, with a
//             start/busy/done handshake.
//  Options  : CONV_CTRL_SAT_EN - when defined, Z samples are clamped to the
//             signed OUT_WIDTH range; otherwise they wrap (low bits kept).
//  Revision : 1.0 - initial release
// ============================================================================

// Combinational two's-complement adder shared by the convolution datapath.
module convolution_processor_adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

module convolution_processor_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   sizeX,
    input  logic [ADDR_WIDTH:0]   sizeY,
    output logic [ADDR_WIDTH-1:0] memX_addr,
    input  logic [DATA_WIDTH-1:0] memX_data,
    output logic [ADDR_WIDTH-1:0] memY_addr,
    input  logic [DATA_WIDTH-1:0] memY_data,
    output logic [ADDR_WIDTH:0]   memZ_addr,
    output logic [OUT_WIDTH-1:0]  memZ_data,
    output logic                  memZ_we,
    output logic                  busy,
    output logic                  done
);
    // Accumulator wide enough for 2^ADDR_WIDTH full-scale products.
    localparam int ACC_WIDTH = 2*DATA_WIDTH + ADDR_WIDTH;
    localparam int PROD_WIDTH = 2*DATA_WIDTH;
    // Index arithmetic width: holds sizeX+sizeY without overflow.
    localparam int CW = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_FETCH = 3'd2,
        S_MAC   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH:0]    r_size_x;
    logic [ADDR_WIDTH:0]    r_size_y;
    logic [ADDR_WIDTH:0]    r_i;
    logic [ADDR_WIDTH-1:0]  r_j;
    logic [ADDR_WIDTH-1:0]  r_j_hi;
    logic [ACC_WIDTH-1:0]   r_acc;

    logic [CW-1:0]          w_i_ext;
    logic [CW-1:0]          w_i_p1;
    logic [CW-1:0]          w_sx_ext;
    logic [CW-1:0]          w_sy_ext;
    logic [ADDR_WIDTH-1:0]  w_j_lo;
    logic [ADDR_WIDTH-1:0]  w_j_hi;
    logic [ADDR_WIDTH-1:0]  w_j_next;
    logic [ADDR_WIDTH-1:0]  w_y_addr_init;
    logic [ADDR_WIDTH-1:0]  w_y_addr_next;
    logic                   w_last_i;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]   w_prod_ext;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic [OUT_WIDTH-1:0]   w_z_data;

    assign w_i_ext  = {1'b0, r_i};
    assign w_i_p1   = w_i_ext + CW'(1);
    assign w_sx_ext = {1'b0, r_size_x};
    assign w_sy_ext = {1'b0, r_size_y};

    // Contributing X window for output i: j in [max(0,i-sizeY+1), min(i,sizeX-1)].
    assign w_j_lo = ADDR_WIDTH'((w_i_p1 > w_sy_ext) ? (w_i_p1 - w_sy_ext) : CW'(0));
    assign w_j_hi = (w_i_ext < w_sx_ext) ? ADDR_WIDTH'(r_i)
                                         : ADDR_WIDTH'(r_size_x - (ADDR_WIDTH+1)'(1));
    assign w_j_next = r_j + ADDR_WIDTH'(1);

    // Y index i-j always lands inside [0, sizeY-1], so truncation is lossless.
    assign w_y_addr_init = ADDR_WIDTH'(r_i - {1'b0, w_j_lo});
    assign w_y_addr_next = ADDR_WIDTH'(r_i - {1'b0, w_j_next});

    assign w_last_i = (w_i_ext == (w_sx_ext + w_sy_ext - CW'(2)));

    // Signed product, sign-extended into the accumulator width.
    assign w_prod     = $signed(memX_data) * $signed(memY_data);
    assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};

    convolution_processor_adder #(
        .DATA_WIDTH (ACC_WIDTH)
    ) u_adder (
        .a   (r_acc),
        .b   (w_prod_ext),
        .sum (w_acc_next)
    );

`ifdef CONV_CTRL_SAT_EN
    localparam logic [ACC_WIDTH-1:0] c_out_max =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_out_min =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Clamp the final sum into the signed output range.
    always_comb begin
        w_z_data = w_acc_next[OUT_WIDTH-1:0];
        if ($signed(w_acc_next) > $signed(c_out_max)) begin
            w_z_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if ($signed(w_acc_next) < $signed(c_out_min)) begin
            w_z_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end
`else
    // Two's-complement wrap: keep the low output bits.
    always_comb begin
        w_z_data = w_acc_next[OUT_WIDTH-1:0];
    end
`endif

    // Sequencer: all outputs are registered and change only on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_size_x  <= '0;
            r_size_y  <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_j_hi    <= '0;
            r_acc     <= '0;
            memX_addr <= '0;
            memY_addr <= '0;
            memZ_addr <= '0;
            memZ_data <= '0;
            memZ_we   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            memZ_we <= 1'b0;
            done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_size_x <= sizeX;
                        r_size_y <= sizeY;
                        r_i      <= '0;
                        busy     <= 1'b1;
                        if ((sizeX == '0) || (sizeY == '0)) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    r_j       <= w_j_lo;
                    r_j_hi    <= w_j_hi;
                    r_acc     <= '0;
                    memX_addr <= w_j_lo;
                    memY_addr <= w_y_addr_init;
                    r_state   <= S_FETCH;
                end
                S_FETCH: begin
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (r_j == r_j_hi) begin
                        memZ_we   <= 1'b1;
                        memZ_addr <= r_i;
                        memZ_data <= w_z_data;
                        r_state   <= S_WRITE;
                    end else begin
                        r_j       <= w_j_next;
                        memX_addr <= w_j_next;
                        memY_addr <= w_y_addr_next;
                        r_state   <= S_FETCH;
                    end
                end
                S_WRITE: begin
                    if (w_last_i) begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_i     <= r_i + (ADDR_WIDTH+1)'(1);
                        r_state <= S_INIT;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
